// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the IF stage: NOP encoding, opcode field position,
// default HALT opcode and fetch FSM state encodings.
package fetch_stage_pkg;

  localparam logic [15:0] NOP_INSTR       = 16'h0000;
  localparam int          OPCODE_MSB      = 15;
  localparam int          OPCODE_LSB      = 12;
  localparam logic [3:0]  HALT_OP_DEFAULT = 4'hF;

  typedef enum logic {
    FETCH_RUN    = 1'b0,
    FETCH_HALTED = 1'b1
  } fetch_state_e;

  function automatic logic [3:0] opcode_of(input logic [15:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: holds on stall, loads a NOP with valid=0 when
// killed, otherwise captures the fetched instruction and its PC+1.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold_i,
  input  logic        kill_i,
  input  logic [15:0] instr_i,
  input  logic [15:0] pc_plus1_i,
  output logic [15:0] instr_o,
  output logic [15:0] pc_plus1_o,
  output logic        valid_o
);

  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_plus1_q, pc_plus1_d;
  logic        valid_q, valid_d;

  always_comb begin
    instr_d    = instr_q;
    pc_plus1_d = pc_plus1_q;
    valid_d    = valid_q;
    if (!hold_i) begin
      if (kill_i) begin
        instr_d    = NOP_INSTR;
        pc_plus1_d = 16'h0000;
        valid_d    = 1'b0;
      end else begin
        instr_d    = instr_i;
        pc_plus1_d = pc_plus1_i;
        valid_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= NOP_INSTR;
      pc_plus1_q <= 16'h0000;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus1_q <= pc_plus1_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_plus1_o = pc_plus1_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: program counter, next-PC selection, HALT freeze FSM, fetch
// counter and the IF/ID register feeding decode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [3:0]  HALT_OP  = HALT_OP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        IF_ID_sync_nop,
  input  logic        ID_stall,
  input  logic        redirect_en,
  input  logic [15:0] redirect_target,
  output logic [15:0] IF_ID_instr,
  output logic [15:0] IF_ID_pc_plus1,
  output logic        IF_ID_valid,
  output logic        halted,
  output logic [15:0] fetch_count
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  fetch_count_q, fetch_count_d;
  logic [15:0]  pc_plus1;
  logic         is_halt_op;
  logic         load_valid;

  assign pc_plus1   = pc_q + 16'd1;
  assign is_halt_op = (opcode_of(imem_data) == HALT_OP);
  // A real instruction enters IF/ID only while running and not flushed.
  assign load_valid = (state_q == FETCH_RUN) && !IF_ID_sync_nop;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_count_d = fetch_count_q;
    if (!ID_stall) begin
      if (redirect_en) begin
        pc_d    = redirect_target;
        state_d = FETCH_RUN;
      end else if (state_q == FETCH_HALTED) begin
        pc_d = pc_q;
      end else if (load_valid && is_halt_op) begin
        pc_d    = pc_q;
        state_d = FETCH_HALTED;
      end else begin
        pc_d = pc_plus1;
      end
      if (load_valid) begin
        fetch_count_d = fetch_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH_RUN;
      pc_q          <= RESET_PC;
      fetch_count_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .hold_i     (ID_stall),
    .kill_i     (!load_valid),
    .instr_i    (imem_data),
    .pc_plus1_i (pc_plus1),
    .instr_o    (IF_ID_instr),
    .pc_plus1_o (IF_ID_pc_plus1),
    .valid_o    (IF_ID_valid)
  );

  assign imem_addr   = pc_q;
  assign halted      = (state_q == FETCH_HALTED);
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, flush/redirect, stall,
// HALT entry/exit, PC and counter wrap, and asynchronous reset.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        IF_ID_sync_nop;
  logic        ID_stall;
  logic        redirect_en;
  logic [15:0] redirect_target;
  logic [15:0] IF_ID_instr;
  logic [15:0] IF_ID_pc_plus1;
  logic        IF_ID_valid;
  logic        halted;
  logic [15:0] fetch_count;

  logic [15:0] imem [0:65535];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign imem_data = imem[imem_addr];

  fetch_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .IF_ID_sync_nop  (IF_ID_sync_nop),
    .ID_stall        (ID_stall),
    .redirect_en     (redirect_en),
    .redirect_target (redirect_target),
    .IF_ID_instr     (IF_ID_instr),
    .IF_ID_pc_plus1  (IF_ID_pc_plus1),
    .IF_ID_valid     (IF_ID_valid),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic applyStimulus(input logic stall, input logic flush,
                               input logic redir, input logic [15:0] target);
    ID_stall        = stall;
    IF_ID_sync_nop  = flush;
    redirect_en     = redir;
    redirect_target = target;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs,
                             input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkIfId(input string tag, input logic [15:0] instr,
                           input logic [15:0] pcp1, input logic valid,
                           input logic [15:0] addr, input logic [15:0] cnt,
                           input logic hlt);
    checkOutput({tag, ".instr"}, IF_ID_instr, instr);
    checkOutput({tag, ".pcp1"},  IF_ID_pc_plus1, pcp1);
    checkOutput({tag, ".valid"}, {15'd0, IF_ID_valid}, {15'd0, valid});
    checkOutput({tag, ".addr"},  imem_addr, addr);
    checkOutput({tag, ".count"}, fetch_count, cnt);
    checkOutput({tag, ".halted"}, {15'd0, halted}, {15'd0, hlt});
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) imem[i] = 16'h0000;
    imem[16'h0000] = 16'h1234;
    imem[16'h0001] = 16'h2345;
    imem[16'h0002] = 16'h3456;
    imem[16'h0003] = 16'h4567;
    imem[16'h0005] = 16'hF000;
    imem[16'h0010] = 16'hD010;
    imem[16'h0011] = 16'hF011;
    imem[16'h0012] = 16'hF012;
    imem[16'h0041] = 16'hA041;
    imem[16'h0042] = 16'hB042;
    imem[16'h0043] = 16'hC043;
    imem[16'hFFFF] = 16'hE0FF;

    rst_n = 1'b0;
    ID_stall = 1'b0; IF_ID_sync_nop = 1'b0; redirect_en = 1'b0; redirect_target = 16'h0;
    #2;
    checkIfId("reset", 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch from RESET_PC
    applyStimulus(0, 0, 0, 16'h0);
    checkIfId("seq0", 16'h1234, 16'h0001, 1'b1, 16'h0001, 16'h0001, 1'b0);
    applyStimulus(0, 0, 0, 16'h0);
    checkIfId("seq1", 16'h2345, 16'h0002, 1'b1, 16'h0002, 16'h0002, 1'b0);
    applyStimulus(0, 0, 0, 16'h0);
    checkIfId("seq2", 16'h3456, 16'h0003, 1'b1, 16'h0003, 16'h0003, 1'b0);

    // Redirect to 0x40 with two flush cycles
    applyStimulus(0, 1, 1, 16'h0040);
    checkIfId("flush0", 16'h0000, 16'h0000, 1'b0, 16'h0040, 16'h0003, 1'b0);
    applyStimulus(0, 1, 0, 16'h0);
    checkIfId("flush1", 16'h0000, 16'h0000, 1'b0, 16'h0041, 16'h0003, 1'b0);
    applyStimulus(0, 0, 0, 16'h0);
    checkIfId("aftflush", 16'hA041, 16'h0042, 1'b1, 16'h0042, 16'h0004, 1'b0);

    // Three-cycle stall, redirect in the middle is ignored
    applyStimulus(1, 0, 0, 16'h0);
    checkIfId("stall0", 16'hA041, 16'h0042, 1'b1, 16'h0042, 16'h0004, 1'b0);
    applyStimulus(1, 0, 1, 16'h0080);
    checkIfId("stall1", 16'hA041, 16'h0042, 1'b1, 16'h0042, 16'h0004, 1'b0);
    applyStimulus(1, 0, 0, 16'h0);
    checkIfId("stall2", 16'hA041, 16'h0042, 1'b1, 16'h0042, 16'h0004, 1'b0);
    applyStimulus(0, 0, 0, 16'h0);
    checkIfId("unstall", 16'hB042, 16'h0043, 1'b1, 16'h0043, 16'h0005, 1'b0);

    // Redirect without flush latches the current fetch, then HALT at 5
    applyStimulus(0, 0, 1, 16'h0005);
    checkIfId("redir5", 16'hC043, 16'h0044, 1'b1, 16'h0005, 16'h0006, 1'b0);
    applyStimulus(0, 0, 0, 16'h0);
    checkIfId("halt", 16'hF000, 16'h0006, 1'b1, 16'h0005, 16'h0007, 1'b1);
    applyStimulus(0, 0, 0, 16'h0);
    checkIfId("halted", 16'h0000, 16'h0000, 1'b0, 16'h0005, 16'h0007, 1'b1);
    applyStimulus(0, 0, 1, 16'h0010);
    checkIfId("resume", 16'h0000, 16'h0000, 1'b0, 16'h0010, 16'h0007, 1'b0);
    applyStimulus(0, 0, 0, 16'h0);
    checkIfId("run10", 16'hD010, 16'h0011, 1'b1, 16'h0011, 16'h0008, 1'b0);

    // Flushed HALT never halts; HALT with redirect keeps running
    applyStimulus(0, 1, 0, 16'h0);
    checkIfId("flushhalt", 16'h0000, 16'h0000, 1'b0, 16'h0012, 16'h0008, 1'b0);
    applyStimulus(0, 0, 1, 16'h0020);
    checkIfId("redirhalt", 16'hF012, 16'h0013, 1'b1, 16'h0020, 16'h0009, 1'b0);

    // PC wrap from 0xFFFF to 0
    applyStimulus(0, 0, 1, 16'hFFFF);
    checkIfId("toFFFF", 16'h0000, 16'h0021, 1'b1, 16'hFFFF, 16'h000A, 1'b0);
    applyStimulus(0, 0, 0, 16'h0);
    checkIfId("pcwrap", 16'hE0FF, 16'h0000, 1'b1, 16'h0000, 16'h000B, 1'b0);

    // Fetch counter wrap: remove HALTs so straight-line fetch never stops
    imem[16'h0005] = 16'h0000;
    imem[16'h0011] = 16'h0000;
    imem[16'h0012] = 16'h0000;
    applyStimulus(0, 0, 0, 16'h0);
    checkOutput("cnt12", fetch_count, 16'h000C);
    repeat (65535 - 12) applyStimulus(0, 0, 0, 16'h0);
    checkOutput("cntFFFF", fetch_count, 16'hFFFF);
    applyStimulus(0, 0, 0, 16'h0);
    checkOutput("cntwrap", fetch_count, 16'h0000);

    // Halt again, then assert reset mid-cycle
    imem[16'h0005] = 16'hF000;
    applyStimulus(0, 0, 1, 16'h0005);
    applyStimulus(0, 0, 0, 16'h0);
    checkOutput("prerst.halted", {15'd0, halted}, 16'h0001);
    #2;
    rst_n = 1'b0;
    #1;
    checkIfId("asyncrst", 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
